// File: rtl/game_state_manager.sv
// Game state manager: score, lives, level and top-level game flow.
// Consumes per-frame hit pulses; drives HUD, level regeneration and invulnerability.
module game_state_manager #(
    parameter int INIT_LIVES        = 3,
    parameter int MAX_LIVES         = 5,
    parameter int SCORE_WIDTH       = 16,
    parameter int DIAMOND_POINTS    = 10,
    parameter int COVID_POINTS      = 5,
    parameter int INVULN_FRAMES     = 30,
    parameter int LEVEL_DONE_FRAMES = 60,
    parameter int NUM_LEVELS        = 3
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   start_key,
    input  logic                   SHP_bumpyDiamond,
    input  logic                   SHP_bumpyHeart,
    input  logic                   SHP_bumpyObstacle,
    input  logic                   SHP_bumpyCovid,
    input  logic                   SHP_bumpyFinishFlag,
    input  logic                   SHP_shootCovid,
    output logic [SCORE_WIDTH-1:0] score,
    output logic [2:0]             lives,
    output logic [1:0]             level,
    output logic [2:0]             game_state,
    output logic                   invulnerable,
    output logic                   level_restart
);

    localparam int SW1 = SCORE_WIDTH + 1;
    localparam int IW  = $clog2(INVULN_FRAMES + 1);
    localparam int DW  = $clog2(LEVEL_DONE_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PLAY       = 3'd1,
        S_HIT        = 3'd2,
        S_LEVEL_DONE = 3'd3,
        S_GAME_OVER  = 3'd4,
        S_WIN        = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic [2:0]             lives_q, lives_d;
    logic [1:0]             level_q, level_d;
    logic [IW-1:0]          inv_cnt_q, inv_cnt_d;
    logic [DW-1:0]          done_cnt_q, done_cnt_d;
    logic                   restart_q, restart_d;
    logic                   invuln_q, invuln_d;

    logic [SW1-1:0]         add;
    logic [SW1-1:0]         sum;
    logic [2:0]             lives_h;
    logic                   damage;

    // Shared arithmetic: saturating score add and heart-adjusted lives
    always_comb begin
        add = '0;
        if (SHP_bumpyDiamond) add = add + SW1'(DIAMOND_POINTS);
        if (SHP_shootCovid)   add = add + SW1'(COVID_POINTS);
        sum = {1'b0, score_q} + add;
        lives_h = lives_q;
        if (SHP_bumpyHeart && (lives_q < 3'(MAX_LIVES)))
            lives_h = lives_q + 3'd1;
        damage = SHP_bumpyObstacle | SHP_bumpyCovid;
    end

    // Next-state logic for the game flow
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        lives_d    = lives_q;
        level_d    = level_q;
        inv_cnt_d  = inv_cnt_q;
        done_cnt_d = done_cnt_q;
        restart_d  = 1'b0;
        unique case (state_q)
            S_IDLE, S_GAME_OVER, S_WIN: begin
                if (start_key) begin
                    state_d    = S_PLAY;
                    score_d    = '0;
                    lives_d    = 3'(INIT_LIVES);
                    level_d    = '0;
                    inv_cnt_d  = '0;
                    done_cnt_d = '0;
                    restart_d  = 1'b1;
                end
            end
            S_PLAY, S_HIT: begin
                score_d = sum[SCORE_WIDTH] ? '1 : sum[SCORE_WIDTH-1:0];
                lives_d = lives_h;
                if (SHP_bumpyFinishFlag) begin
                    // finishing wins over damage and ends any immunity
                    state_d    = S_LEVEL_DONE;
                    done_cnt_d = DW'(LEVEL_DONE_FRAMES);
                    inv_cnt_d  = '0;
                end else if (state_q == S_PLAY && damage) begin
                    if (lives_h == 3'd1) begin
                        lives_d = 3'd0;
                        state_d = S_GAME_OVER;
                    end else begin
                        lives_d   = lives_h - 3'd1;
                        state_d   = S_HIT;
                        inv_cnt_d = IW'(INVULN_FRAMES);
                    end
                end else if (state_q == S_HIT && startOfFrame) begin
                    if (inv_cnt_q == IW'(1)) begin
                        state_d   = S_PLAY;
                        inv_cnt_d = '0;
                    end else begin
                        inv_cnt_d = inv_cnt_q - IW'(1);
                    end
                end
            end
            S_LEVEL_DONE: begin
                if (startOfFrame) begin
                    if (done_cnt_q == DW'(1)) begin
                        done_cnt_d = '0;
                        if (level_q == 2'(NUM_LEVELS - 1)) begin
                            state_d = S_WIN;
                        end else begin
                            level_d   = level_q + 2'd1;
                            state_d   = S_PLAY;
                            restart_d = 1'b1;
                        end
                    end else begin
                        done_cnt_d = done_cnt_q - DW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        invuln_d = (state_d == S_HIT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            score_q    <= '0;
            lives_q    <= 3'(INIT_LIVES);
            level_q    <= '0;
            inv_cnt_q  <= '0;
            done_cnt_q <= '0;
            restart_q  <= 1'b0;
            invuln_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            inv_cnt_q  <= inv_cnt_d;
            done_cnt_q <= done_cnt_d;
            restart_q  <= restart_d;
            invuln_q   <= invuln_d;
        end
    end

    assign score         = score_q;
    assign lives         = lives_q;
    assign level         = level_q;
    assign game_state    = state_q;
    assign invulnerable  = invuln_q;
    assign level_restart = restart_q;

endmodule

// File: doc/game_state_manager.md
Name: game_state_manager

Overview:
- Consumes the per-frame single-hit collision pulses from the collision/game controller and maintains score, lives, level and top-level game state.
- Applies an invulnerability window after damage and sequences level completion, game over and win.
- Feeds the HUD/score display, the level object generators (via level_restart) and the Bumpy motion block (via invulnerable).

Parameters:
- INIT_LIVES, 3, lives loaded on game start (1..MAX_LIVES)
- MAX_LIVES, 5, life count saturation ceiling (≤7)
- SCORE_WIDTH, 16, score register width
- DIAMOND_POINTS, 10, points per diamond pickup
- COVID_POINTS, 5, points per shot covid
- INVULN_FRAMES, 30, frames of damage immunity after a hit (≥1)
- LEVEL_DONE_FRAMES, 60, frames spent in level-complete pause (≥1)
- NUM_LEVELS, 3, number of levels (1..4)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- start_key  in  1  one-cycle start/restart request
- SHP_bumpyDiamond  in  1  diamond pickup pulse
- SHP_bumpyHeart  in  1  heart pickup pulse
- SHP_bumpyObstacle  in  1  damage pulse
- SHP_bumpyCovid  in  1  damage pulse
- SHP_bumpyFinishFlag  in  1  level-finish pulse
- SHP_shootCovid  in  1  shot-hit-covid pulse
- score  out  SCORE_WIDTH  current score
- lives  out  3  current lives
- level  out  2  current level index, 0-based
- game_state  out  3  IDLE=0, PLAY=1, HIT=2, LEVEL_DONE=3, GAME_OVER=4, WIN=5
- invulnerable  out  1  high while in HIT
- level_restart  out  1  one-cycle pulse: regenerate level objects

Behaviour:
- Reset values: state IDLE, score 0, lives INIT_LIVES, level 0, invulnerable 0, level_restart 0, both frame counters 0. Reset is asynchronous and fully effective mid-operation.
- All outputs are registered. An input pulse sampled at edge N is reflected at the outputs after edge N; latency is 1 cycle.

IDLE:
- start_key → PLAY; load score 0, lives INIT_LIVES, level 0; pulse level_restart.
- All other inputs are ignored.

PLAY:
- Diamond: score += DIAMOND_POINTS.
- shootCovid: score += COVID_POINTS. If both arrive in the same cycle, add both.
- Score saturates at 2^SCORE_WIDTH−1 and never wraps.
- Heart: lives += 1, saturating at MAX_LIVES.
- Damage (obstacle OR covid, counted once even if both are high):
  - If lives (after any same-cycle heart) == 1: lives → 0, state → GAME_OVER.
  - Otherwise: lives −1, state → HIT, inv_cnt ← INVULN_FRAMES.
- Same-cycle heart + damage: heart applies first, then damage. Net lives are unchanged and the state still enters HIT.
- FinishFlag: state → LEVEL_DONE, done_cnt ← LEVEL_DONE_FRAMES. FinishFlag takes priority over same-cycle damage (damage is dropped). Score and heart in the same cycle are still applied.

HIT:
- Score, heart and finish behave as in PLAY. Damage is ignored.
- On each startOfFrame, inv_cnt decrements. On the startOfFrame where inv_cnt == 1, go to PLAY.
- FinishFlag in HIT cancels invulnerability and goes to LEVEL_DONE.

LEVEL_DONE:
- All events are ignored.
- On each startOfFrame, done_cnt decrements. On the startOfFrame where done_cnt == 1:
  - If level == NUM_LEVELS−1 → WIN.
  - Else level += 1, state → PLAY, pulse level_restart. Lives and score are retained.

GAME_OVER / WIN:
- Outputs are frozen and events are ignored.
- start_key → same action as start from IDLE.

General:
- start_key in PLAY, HIT or LEVEL_DONE is ignored.
- invulnerable = (state == HIT).
- level_restart is high for exactly 1 cycle per restart.
- Counters only change on startOfFrame cycles, so timing is frame-accurate regardless of clk frequency.

Test Plan:
- Reset, then start_key → game_state=1, lives=3, score=0, level=0, level_restart high for 1 cycle. Then 3 diamond pulses plus 1 shootCovid → score=35.
- In PLAY with lives=3, send SHP_bumpyObstacle → next cycle lives=2, state=2, invulnerable=1. Send covid 5 frames later → lives stay 2. After 30 startOfFrame pulses → state=1, invulnerable=0.
- Set lives=5, heart → lives=5 (saturated). Heart + obstacle in the same cycle at lives=2 → lives=2, state=HIT.
- Lives=1, obstacle and covid together → lives=0, state=4. Further pulses have no effect. start_key → state=1, lives=3, score=0, level=0.
- FinishFlag + obstacle in the same cycle at level 0 → state=3, lives unchanged. After 60 frames → level=1, state=1, one level_restart pulse. Repeat at level 2 → state=5 (WIN), no level_restart.
- Drive score to 65530 with SCORE_WIDTH=16, then diamond → score=65535 (saturated). Assert resetN low mid-HIT → all outputs return to reset values immediately.
